// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clock cycles.
// Optional high-time measurement is built only when PERIOD_METER_DUTY_EN is defined.
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C    = WIDTH'(0);

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, delay_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic             rise_s;
  logic             at_limit_s;
`ifdef PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             fall_s;
`endif

  assign rise_s     = sync2_q & ~delay_q;
  assign at_limit_s = (cnt_q == TIMEOUT_C);
`ifdef PERIOD_METER_DUTY_EN
  assign fall_s     = ~sync2_q & delay_q;
`endif

  // Next-state, counter and capture logic; enable low overrides every event.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    locked_d  = locked_q;
`ifdef PERIOD_METER_DUTY_EN
    cap_d     = cap_q;
    high_d    = high_q;
`endif
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = ZERO_C;
      locked_d = 1'b0;
`ifdef PERIOD_METER_DUTY_EN
      cap_d    = ZERO_C;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = ZERO_C;
        end
        ARM: begin
          if (rise_s) begin
            state_d = MEASURE;
            cnt_d   = ONE_C;
`ifdef PERIOD_METER_DUTY_EN
            cap_d   = ZERO_C;
`endif
          end else if (at_limit_s) begin
            timeout_d = 1'b1;
            cnt_d     = ZERO_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        MEASURE: begin
          // A rise landing on the limit cycle is a valid capture, not a timeout.
          if (rise_s) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = ONE_C;
`ifdef PERIOD_METER_DUTY_EN
            high_d   = cap_q;
            cap_d    = ZERO_C;
`endif
          end else if (at_limit_s) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = ZERO_C;
            state_d   = ARM;
`ifdef PERIOD_METER_DUTY_EN
            cap_d     = ZERO_C;
`endif
          end else begin
            cnt_d = cnt_q + ONE_C;
`ifdef PERIOD_METER_DUTY_EN
            if (fall_s) begin
              cap_d = cnt_q;
            end else begin
              cap_d = cap_q;
            end
`endif
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = ZERO_C;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      delay_q   <= 1'b0;
      cnt_q     <= ZERO_C;
      period_q  <= ZERO_C;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
      cap_q     <= ZERO_C;
      high_q    <= ZERO_C;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sig_in;
      sync2_q   <= sync1_q;
      delay_q   <= sync2_q;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
`ifdef PERIOD_METER_DUTY_EN
      cap_q     <= cap_d;
      high_q    <= high_d;
`endif
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign locked  = locked_q;
`ifdef PERIOD_METER_DUTY_EN
  assign high_time = high_q;
`else
  assign high_time = ZERO_C;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter (WIDTH=16, TIMEOUT=100).
module tb_period_meter;

  localparam int W  = 16;
  localparam int TO = 100;
`ifdef PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int valid_cnt = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
  int to_cnt = 0, last_to_cyc = 0, prev_to_cyc = 0;
  int v0, t0;

  period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period(period), .high_time(high_time), .valid(valid),
    .timeout(timeout), .locked(locked)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clock) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
    end
    if (timeout) begin
      to_cnt      <= to_cnt + 1;
      prev_to_cyc <= last_to_cyc;
      last_to_cyc <= cyc;
    end
  end

  function automatic int hexp(input int h);
    return DUTY ? h : 0;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        sig_in = (c < h);
        step(1);
      end
    end
  endtask

  task automatic wait_to(input string tag, input int budget);
    int start = to_cnt;
    int k = 0;
    while (to_cnt == start && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, to_cnt - start, 1);
  endtask

  initial begin
    step(2);
    check_eq("rst_period", int'(period), 0);
    check_eq("rst_high", int'(high_time), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    check_eq("rst_locked", int'(locked), 0);
    reset = 1'b0;
    step(1);

    // Period 8, high 3
    enable = 1'b1;
    step(2);
    v0 = valid_cnt; t0 = to_cnt;
    wave(8, 3, 6);
    check_eq("p8_valid_count", valid_cnt - v0, 5);
    check_eq("p8_valid_spacing", last_valid_cyc - prev_valid_cyc, 8);
    check_eq("p8_period", int'(period), 8);
    check_eq("p8_high", int'(high_time), hexp(3));
    check_eq("p8_locked", int'(locked), 1);
    check_eq("p8_no_timeout", to_cnt - t0, 0);

    // Lock on period 20, then stop the input
    v0 = valid_cnt;
    wave(20, 7, 3);
    check_eq("p20_valid_count", valid_cnt - v0, 3);
    check_eq("p20_period", int'(period), 20);
    check_eq("p20_high", int'(high_time), hexp(7));
    check_eq("p20_locked", int'(locked), 1);
    v0 = valid_cnt;
    wait_to("stop_timeout_seen", 150);
    check_eq("stop_timeout_delay", last_to_cyc - last_valid_cyc, 100);
    check_eq("stop_locked", int'(locked), 0);
    check_eq("stop_period_held", int'(period), 20);
    check_eq("stop_high_held", int'(high_time), hexp(7));
    check_eq("stop_no_valid", valid_cnt - v0, 0);

    // Repeating timeouts while armed
    wait_to("arm_timeout1_seen", 150);
    check_eq("arm_timeout1_spacing", last_to_cyc - prev_to_cyc, 101);
    wait_to("arm_timeout2_seen", 150);
    check_eq("arm_timeout2_spacing", last_to_cyc - prev_to_cyc, 101);
    check_eq("arm_no_valid", valid_cnt - v0, 0);
    check_eq("arm_locked", int'(locked), 0);

    // Enable dropped exactly on a rise-detect cycle
    v0 = valid_cnt;
    wave(10, 4, 3);
    check_eq("p10_valid_count", valid_cnt - v0, 2);
    check_eq("p10_period", int'(period), 10);
    check_eq("p10_high", int'(high_time), hexp(4));
    v0 = valid_cnt; t0 = to_cnt;
    sig_in = 1'b1;
    step(2);
    enable = 1'b0;
    step(1);
    sig_in = 1'b0;
    step(5);
    check_eq("dis_no_valid", valid_cnt - v0, 0);
    check_eq("dis_no_timeout", to_cnt - t0, 0);
    check_eq("dis_locked", int'(locked), 0);
    check_eq("dis_period_held", int'(period), 10);
    enable = 1'b1;
    step(2);
    v0 = valid_cnt;
    wave(10, 4, 1);
    check_eq("reen_first_rise_no_valid", valid_cnt - v0, 0);
    wave(10, 4, 1);
    check_eq("reen_second_rise_valid", valid_cnt - v0, 1);
    check_eq("reen_period", int'(period), 10);
    check_eq("reen_locked", int'(locked), 1);

    // Asynchronous reset with the counter at 5
    sig_in = 1'b1;
    step(3);
    sig_in = 1'b0;
    step(4);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_period", int'(period), 0);
    check_eq("arst_high", int'(high_time), 0);
    check_eq("arst_valid", int'(valid), 0);
    check_eq("arst_locked", int'(locked), 0);
    check_eq("arst_timeout", int'(timeout), 0);
    step(1);
    reset = 1'b0;
    step(2);
    v0 = valid_cnt;
    wave(12, 5, 1);
    check_eq("p12_first_rise_no_valid", valid_cnt - v0, 0);
    wave(12, 5, 2);
    check_eq("p12_valid_count", valid_cnt - v0, 2);
    check_eq("p12_period", int'(period), 12);
    check_eq("p12_high", int'(high_time), hexp(5));
    check_eq("p12_locked", int'(locked), 1);

    // Rise on the same cycle the counter reaches TIMEOUT
    v0 = valid_cnt; t0 = to_cnt;
    wave(100, 50, 2);
    check_eq("lim_valid_count", valid_cnt - v0, 2);
    check_eq("lim_period", int'(period), 100);
    check_eq("lim_high", int'(high_time), hexp(50));
    check_eq("lim_no_timeout", to_cnt - t0, 0);
    check_eq("lim_locked", int'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
